// File: rtl/ct_butterfly_addsub.sv
// ct_butterfly_addsub: modular add/sub back end of a Cooley-Tukey butterfly.
// The top operand a is delayed to line up with the multiplier result bw.
// The block then registers (a + bw) mod q and (a - bw) mod q.
// A pair counter flags the last butterfly of each layer.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   valid_in  in   a_in valid; matching b enters the multiplier this cycle
//   a_in      in   top operand, [0, q-1]
//   bw_in     in   multiplier result, MUL_LAT cycles after valid_in
//   sum_out   out  (a + bw) mod q
//   diff_out  out  (a - bw) mod q
//   valid_out out  sum_out/diff_out valid
//   last_out  out  N_PAIRS-th output of a layer
module ct_butterfly_addsub #(
    parameter int data_width = 12,
    parameter int q          = 3329,
    parameter int MUL_LAT    = 3,
    parameter int N_PAIRS    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [data_width-1:0] a_in,
    input  logic [data_width-1:0] bw_in,
    output logic [data_width-1:0] sum_out,
    output logic [data_width-1:0] diff_out,
    output logic                  valid_out,
    output logic                  last_out
);

    localparam int CW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [data_width:0] QX = (data_width + 1)'(q);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_PAIRS - 1);

    logic [data_width-1:0] a_sr [MUL_LAT];
    logic [MUL_LAT-1:0]    v_sr;
    logic [data_width-1:0] a_d;
    logic                  v_d;
    logic [CW-1:0]         cnt;

    logic [data_width:0]   s;
    logic [data_width:0]   d;
    logic [data_width-1:0] sum_n;
    logic [data_width-1:0] diff_n;

    assign a_d = a_sr[MUL_LAT-1];
    assign v_d = v_sr[MUL_LAT-1];

    // Delay line for {valid, a}, matched to the multiplier latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_sr <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                a_sr[i] <= '0;
            end
        end else begin
            v_sr[0] <= valid_in;
            a_sr[0] <= a_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                a_sr[i] <= a_sr[i-1];
            end
        end
    end

    // One conditional correction suffices because both operands are < q.
    // The difference's top bit acts as the sign of the 13-bit result.
    always_comb begin
        s = {1'b0, a_d} + {1'b0, bw_in};
        d = {1'b0, a_d} - {1'b0, bw_in};
        if (s >= QX) begin
            sum_n = data_width'(s - QX);
        end else begin
            sum_n = data_width'(s);
        end
        if (d[data_width]) begin
            diff_n = data_width'(d + QX);
        end else begin
            diff_n = data_width'(d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_out   <= '0;
            diff_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            cnt       <= '0;
        end else begin
            valid_out <= v_d;
            last_out  <= v_d && (cnt == CNT_LAST);
            if (v_d) begin
                sum_out  <= sum_n;
                diff_out <= diff_n;
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ct_butterfly_addsub.sv
// Directed testbench for ct_butterfly_addsub.
// bw_in comes from a 3-cycle delay of b, like the upstream multiplier.
module tb_ct_butterfly_addsub;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [11:0] a_in;
    logic [11:0] bw_in;
    logic [11:0] sum_out;
    logic [11:0] diff_out;
    logic        valid_out;
    logic        last_out;

    int total = 0;
    int bad   = 0;

    // b delay line (multiplier stand-in) and expected-output pipeline
    int bd [3];
    bit pv [4];
    int ps [4];
    int pd [4];
    int mcnt;
    int hsum;
    int hdiff;

    ct_butterfly_addsub dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .a_in      (a_in),
        .bw_in     (bw_in),
        .sum_out   (sum_out),
        .diff_out  (diff_out),
        .valid_out (valid_out),
        .last_out  (last_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    function automatic int msum(input int a, input int b);
        return (a + b) % Q;
    endfunction

    function automatic int mdiff(input int a, input int b);
        return (a - b + Q) % Q;
    endfunction

    task automatic shift_b(input int b);
        bd[2] = bd[1];
        bd[1] = bd[0];
        bd[0] = b;
    endtask

    // One clock: drive inputs, clock, then check the output due now.
    task automatic step(input bit v, input int a, input int b,
                        input int es, input int ed);
        bit elast;
        valid_in = v;
        a_in     = 12'(a);
        bw_in    = 12'(bd[2]);
        @(posedge clk);
        #1;
        shift_b(b);
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            ps[i] = ps[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = v;
        ps[0] = es;
        pd[0] = ed;
        chk("valid", 32'(valid_out), 32'(pv[3]));
        if (pv[3]) begin
            elast = (mcnt == 255);
            hsum  = ps[3];
            hdiff = pd[3];
            mcnt  = elast ? 0 : mcnt + 1;
        end else begin
            elast = 1'b0;
        end
        chk("sum", 32'(sum_out), 32'(hsum));
        chk("diff", 32'(diff_out), 32'(hdiff));
        chk("last", 32'(last_out), 32'(elast));
        chk("cnt", 32'(dut.cnt), 32'(mcnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 0, 0, 0, 0);
        end
    endtask

    task automatic rnd_pair(input bit v);
        int a;
        int b;
        a = int'($urandom_range(0, Q - 1));
        b = int'($urandom_range(0, Q - 1));
        step(v, a, b, msum(a, b), mdiff(a, b));
    endtask

    // One reset cycle with valid_in high, which must be ignored.
    task automatic reset_cycle();
        rst      = 1'b1;
        valid_in = 1'b1;
        a_in     = 12'd1234;
        bw_in    = 12'(bd[2]);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        shift_b(777);
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
        end
        mcnt  = 0;
        hsum  = 0;
        hdiff = 0;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_diff", 32'(diff_out), 32'd0);
        chk("rst_last", 32'(last_out), 32'd0);
        chk("rst_cnt", 32'(dut.cnt), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        a_in     = '0;
        bw_in    = '0;
        for (int i = 0; i < 3; i++) bd[i] = 0;
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        mcnt = 0;
        hsum = 0;
        hdiff = 0;
        @(posedge clk);
        reset_cycle();

        // reduction corners, one at a time
        step(1'b1, 3000, 1000, 671, 2000);
        idle(4);
        step(1'b1, 100, 200, 300, 3229);
        idle(4);
        step(1'b1, 1664, 1665, 0, 3328);
        idle(4);
        step(1'b1, 3328, 3328, 3327, 0);
        idle(4);
        step(1'b1, 0, 0, 0, 0);
        idle(4);

        // streaming one layer from count 0
        reset_cycle();
        for (int i = 0; i < 256; i++) rnd_pair(1'b1);
        idle(5);

        // bubbles 1,0,0,1,1,0,1
        rnd_pair(1'b1);
        rnd_pair(1'b0);
        rnd_pair(1'b0);
        rnd_pair(1'b1);
        rnd_pair(1'b1);
        rnd_pair(1'b0);
        rnd_pair(1'b1);
        idle(5);

        // reset mid-stream: 5 pairs, reset after the 2nd output
        for (int i = 0; i < 5; i++) rnd_pair(1'b1);
        reset_cycle();
        for (int i = 0; i < 3; i++) rnd_pair(1'b1);
        idle(6);

        // two layers back to back
        reset_cycle();
        for (int i = 0; i < 512; i++) rnd_pair(1'b1);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ct_butterfly_addsub.md
# ct_butterfly_addsub

Modular add/subtract back end of the Cooley-Tukey butterfly, directly downstream of the q = 3329 Plantard constant multiplier. Each butterfly presents its top operand `a` here at the same time its bottom operand `b` enters the multiplier. The block delays `a` and its valid flag to line up with the multiplier result `bw`, then registers `(a + bw) mod q` and `(a - bw) mod q`. A pair counter flags the last butterfly of each NTT layer so the layer controller can switch stages.

## Interface
- `data_width`, 12: coefficient width.
- `q`, 3329: modulus.
- `MUL_LAT`, 3: cycles from a value entering the upstream multiplier to its registered result appearing on `bw_in`; must be ≥ 1.
- `N_PAIRS`, 256: butterflies per layer; the pair counter wraps at this value.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  `a_in` is valid this cycle; the matching `b` enters the multiplier this same cycle.
- `a_in`  in  `data_width`  top operand, range [0, q-1].
- `bw_in`  in  `data_width`  multiplier output, range [0, q-1]; belongs to the `valid_in` seen `MUL_LAT` cycles earlier.
- `sum_out`  out  `data_width`  `(a + bw) mod q`.
- `diff_out`  out  `data_width`  `(a - bw) mod q`.
- `valid_out`  out  1  `sum_out`/`diff_out` valid.
- `last_out`  out  1  high together with `valid_out` on the `N_PAIRS`-th output of a layer.

## Operation
- **Delay line.** A shift register of `MUL_LAT` stages carries `{valid, a}`. The output stage, `a_d`/`v_d`, lines up with `bw_in`.
- **Sum path.** `s = a_d + bw_in`, computed 13 bits wide. If `s ≥ q`, `sum = s - q`; otherwise `sum = s`.
- **Difference path.** `d = a_d - bw_in`, computed 13 bits signed. If `d < 0`, `diff = d + q`; otherwise `diff = d`.
- **Output registers.**
  - When `v_d = 1`: `sum_out`/`diff_out` load the new results and `valid_out` is 1.
  - When `v_d = 0`: `valid_out` is 0 and `sum_out`/`diff_out` hold their previous values.
- **Pair counter.** `cnt` has `clog2(N_PAIRS)` bits.
  - It increments on each cycle where `v_d = 1`.
  - When `cnt = N_PAIRS - 1`, that output registers `last_out = 1` and `cnt` wraps to 0.
  - `last_out` is 0 on every other cycle.
- **Throughput and flow control.** One butterfly per cycle, with no backpressure. Gaps in `valid_in` pass through unchanged; the counter does not advance during gaps.
- **Operand ranges.** Inputs ≥ q are outside the contract. With both inputs in [0, q-1], both results stay in [0, q-1] and never equal q.

## Timing
- **Latency.** `valid_in` at cycle t produces `valid_out` at cycle t + `MUL_LAT` + 1 (4 cycles at the default). `bw_in` is sampled at t + `MUL_LAT`.
- **Reset values.** After `rst` is sampled high:
  - all delay-line valid bits are 0 and stored `a` values are 0;
  - `sum_out`, `diff_out`, `valid_out`, `last_out` and `cnt` are all 0.
- **Reset mid-stream.** In-flight butterflies are discarded. `bw_in` values the multiplier produces afterwards are ignored, because their valid bits were cleared. The first `valid_in` after reset is released produces output exactly `MUL_LAT` + 1 cycles later, and its count is 0.
- **`valid_in` while `rst` is high.** It is ignored.
- **Counter wrap on back-to-back layers.** There is no bubble at the wrap. Output number `N_PAIRS` + 1 carries `last_out = 0` and counts as 0 of the next layer.

## Test plan
- **Reduction corners** (q = 3329), latency 4, each pair issued singly:
  - (a, bw) = (3000, 1000) → sum 671, diff 2000.
  - (100, 200) → sum 300, diff 3229.
  - (1664, 1665) → sum 0, diff 3328.
  - (3328, 3328) → sum 3327, diff 0.
  - (0, 0) → sum 0, diff 0.
- **Streaming.** 256 random valid pairs back to back, with the bench model feeding `bw_in` through a 3-cycle delay → 256 consecutive `valid_out`. Every result matches the golden mod-q model, and `last_out` is high only on the 256th output.
- **Bubbles.** `valid_in` pattern 1,0,0,1,1,0,1 → `valid_out` shows the same pattern shifted by 4 cycles. Outputs hold their values during gaps, and `cnt` advances by 4.
- **Reset mid-stream.** Issue 5 pairs, assert `rst` for 1 cycle at the cycle after the 2nd output, then issue 3 new pairs:
  - no outputs from the discarded pairs appear;
  - all outputs read 0 after reset;
  - the 3 new pairs come out after 4 cycles, with count restarting at 0.
- **Layer wrap.** 512 back-to-back pairs → `last_out` pulses on outputs 256 and 512 only, with no gap between layers.
